sync_ctrl_8b10b: RTL and testbench

- Link synchronisation controller for the 8b10b receive path.
- Sits after the 8b10b deserializer and symbol decoder; consumes per-pair status (comma in first symbol, per-symbol code errors).
- Sequences the deserializer's realign enable: open while hunting, locked once synced.
- Declares sync acquired/lost with hysteresis and keeps a saturating symbol-error counter.

---
 rtl/sync_ctrl_8b10b.sv | 166 ++++++++++++++++
 tb/tb_sync_ctrl_8b10b.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ctrl_8b10b.sv
// Link synchronisation controller for an 8b10b receive path: LOS/ACQ/SYNC hunting with hysteresis.
// Optional sync-loss counter on lossCount_o is enabled by defining SYNC_CTRL_LOSS_CNT_EN.
module sync_ctrl_8b10b #(
   parameter int ACQ_COMMAS  = 3,
   parameter int ACQ_TIMEOUT = 16,
   parameter int ERR_LIMIT   = 4,
   parameter int GOOD_RUN    = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic             komma_i,
   input  logic [1:0]       codeErr_i,
   input  logic             clrCount_i,
   output logic             enReAlign_o,
   output logic             synced_o,
   output logic             syncLoss_o,
   output logic [CNT_W-1:0] errCount_o,
   output logic [7:0]       lossCount_o
);

   typedef enum logic [1:0] {
      ST_LOS  = 2'd0,
      ST_ACQ  = 2'd1,
      ST_SYNC = 2'd2
   } state_t;

   state_t           r_state, w_state_next;
   logic [3:0]       r_comma_cnt, w_comma_next;
   logic [7:0]       r_timeout_cnt, w_timeout_next;
   logic [3:0]       r_credits, w_credits_next;
   logic [7:0]       r_good_cnt, w_good_next;
   logic             r_sync_loss, w_sync_loss_next;
   logic [CNT_W-1:0] r_err_cnt, w_err_next;
   logic [CNT_W:0]   w_err_sum;
   logic [1:0]       w_err_inc;
   logic             w_bad;

   assign w_bad = |codeErr_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= ST_LOS;
         r_comma_cnt   <= 4'd0;
         r_timeout_cnt <= 8'd0;
         r_credits     <= 4'd0;
         r_good_cnt    <= 8'd0;
         r_sync_loss   <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_comma_cnt   <= w_comma_next;
         r_timeout_cnt <= w_timeout_next;
         r_credits     <= w_credits_next;
         r_good_cnt    <= w_good_next;
         r_sync_loss   <= w_sync_loss_next;
         r_err_cnt     <= w_err_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_comma_next     = r_comma_cnt;
      w_timeout_next   = r_timeout_cnt;
      w_credits_next   = r_credits;
      w_good_next      = r_good_cnt;
      w_sync_loss_next = 1'b0;
      if (valid_i) begin
         case (r_state)
            ST_LOS: begin
               if (!w_bad && komma_i) begin
                  if (ACQ_COMMAS == 1) begin
                     w_state_next   = ST_SYNC;
                     w_credits_next = 4'(ERR_LIMIT);
                     w_good_next    = 8'd0;
                  end else begin
                     w_state_next   = ST_ACQ;
                     w_comma_next   = 4'd1;
                     w_timeout_next = 8'd0;
                  end
               end
            end
            ST_ACQ: begin
               if (w_bad) begin
                  w_state_next = ST_LOS;
               end else if (komma_i) begin
                  w_comma_next   = r_comma_cnt + 4'd1;
                  w_timeout_next = 8'd0;
                  if (r_comma_cnt + 4'd1 == 4'(ACQ_COMMAS)) begin
                     w_state_next   = ST_SYNC;
                     w_credits_next = 4'(ERR_LIMIT);
                     w_good_next    = 8'd0;
                  end
               end else begin
                  w_timeout_next = r_timeout_cnt + 8'd1;
                  if (r_timeout_cnt + 8'd1 == 8'(ACQ_TIMEOUT)) begin
                     w_state_next = ST_LOS;
                  end
               end
            end
            ST_SYNC: begin
               if (w_bad) begin
                  w_credits_next = r_credits - 4'd1;
                  w_good_next    = 8'd0;
                  if (r_credits == 4'd1) begin
                     w_state_next     = ST_LOS;
                     w_sync_loss_next = 1'b1;
                  end
               end else if (r_credits == 4'(ERR_LIMIT)) begin
                  // full credit: a good run has nothing to restore
                  w_good_next = 8'd0;
               end else if (r_good_cnt + 8'd1 == 8'(GOOD_RUN)) begin
                  w_good_next    = 8'd0;
                  w_credits_next = r_credits + 4'd1;
               end else begin
                  w_good_next = r_good_cnt + 8'd1;
               end
            end
            default: begin
               w_state_next = ST_LOS;
            end
         endcase
      end
   end

   // Errors counted while SYNC is the current state, including the losing pair.
   assign w_err_inc = (valid_i && r_state == ST_SYNC) ?
                      (2'(codeErr_i[1]) + 2'(codeErr_i[0])) : 2'd0;
   assign w_err_sum = {1'b0, r_err_cnt} + {{(CNT_W-1){1'b0}}, w_err_inc};

   always_comb begin
      w_err_next = r_err_cnt;
      if (clrCount_i) begin
         w_err_next = {{(CNT_W-2){1'b0}}, w_err_inc};
      end else if (w_err_sum[CNT_W]) begin
         w_err_next = '1;
      end else begin
         w_err_next = w_err_sum[CNT_W-1:0];
      end
   end

   assign enReAlign_o = (r_state == ST_LOS);
   assign synced_o    = (r_state == ST_SYNC);
   assign syncLoss_o  = r_sync_loss;
   assign errCount_o  = r_err_cnt;

`ifdef SYNC_CTRL_LOSS_CNT_EN
   logic [7:0] r_loss_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_loss_cnt <= 8'd0;
      end else if (clrCount_i) begin
         r_loss_cnt <= 8'd0;
      end else if (w_sync_loss_next && r_loss_cnt != 8'hFF) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign lossCount_o = r_loss_cnt;
`else
   assign lossCount_o = 8'd0;
`endif

endmodule

// File: tb/tb_sync_ctrl_8b10b.sv
// Scoreboard bench for sync_ctrl_8b10b: driver feeds a behavioural link model, monitor compares each cycle.
// Uses CNT_W=8 so the error counter saturation point is reachable in a short run.
module tb_sync_ctrl_8b10b;

   localparam int TB_CNT_W = 8;
   localparam int MAXV     = (1 << TB_CNT_W) - 1;
   localparam int P_COMMAS = 3;
   localparam int P_TMO    = 16;
   localparam int P_LIMIT  = 4;
   localparam int P_RUN    = 4;

   localparam int HUNT    = 0;
   localparam int ACQUIRE = 1;
   localparam int LOCKED  = 2;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                valid_i = 1'b0;
   logic                komma_i = 1'b0;
   logic [1:0]          codeErr_i = 2'b00;
   logic                clrCount_i = 1'b0;
   logic                enReAlign_o;
   logic                synced_o;
   logic                syncLoss_o;
   logic [TB_CNT_W-1:0] errCount_o;
   logic [7:0]          lossCount_o;

   sync_ctrl_8b10b #(
      .ACQ_COMMAS (P_COMMAS),
      .ACQ_TIMEOUT(P_TMO),
      .ERR_LIMIT  (P_LIMIT),
      .GOOD_RUN   (P_RUN),
      .CNT_W      (TB_CNT_W)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .komma_i    (komma_i),
      .codeErr_i  (codeErr_i),
      .clrCount_i (clrCount_i),
      .enReAlign_o(enReAlign_o),
      .synced_o   (synced_o),
      .syncLoss_o (syncLoss_o),
      .errCount_o (errCount_o),
      .lossCount_o(lossCount_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       en;
      logic       syn;
      logic       loss;
      logic [7:0] err;
      logic [7:0] lcnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_txn    = 0;

   // link model state
   int m_st, m_commas, m_idle, m_credits, m_goodrun, m_err, m_lcnt;
   bit m_lost;

`ifdef SYNC_CTRL_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_st = HUNT; m_commas = 0; m_idle = 0; m_credits = 0;
      m_goodrun = 0; m_err = 0; m_lcnt = 0; m_lost = 0;
   endfunction

   function automatic void model_step(input bit v, input bit k, input bit [1:0] e, input bit c);
      int   inc;
      exp_t x;
      inc    = (v && m_st == LOCKED) ? $countones(e) : 0;
      m_lost = 0;
      if (v) begin
         if (m_st == HUNT) begin
            if (e == 0 && k) begin
               m_commas = 1; m_idle = 0;
               if (m_commas == P_COMMAS) begin
                  m_st = LOCKED; m_credits = P_LIMIT; m_goodrun = 0;
               end else begin
                  m_st = ACQUIRE;
               end
            end
         end else if (m_st == ACQUIRE) begin
            if (e != 0) begin
               m_st = HUNT;
            end else if (k) begin
               m_commas++; m_idle = 0;
               if (m_commas == P_COMMAS) begin
                  m_st = LOCKED; m_credits = P_LIMIT; m_goodrun = 0;
               end
            end else begin
               m_idle++;
               if (m_idle == P_TMO) m_st = HUNT;
            end
         end else begin
            if (e != 0) begin
               m_credits--; m_goodrun = 0;
               if (m_credits == 0) begin
                  m_st = HUNT; m_lost = 1;
               end
            end else begin
               m_goodrun++;
               if (m_goodrun == P_RUN) begin
                  m_goodrun = 0;
                  m_credits = (m_credits + 1 > P_LIMIT) ? P_LIMIT : m_credits + 1;
               end
               if (m_credits == P_LIMIT) m_goodrun = 0;
            end
         end
      end
      m_err = c ? inc : ((m_err + inc > MAXV) ? MAXV : m_err + inc);
      if (LOSS_EN) begin
         if (c) m_lcnt = 0;
         else if (m_lost && m_lcnt < 255) m_lcnt++;
      end
      x.en   = (m_st == HUNT);
      x.syn  = (m_st == LOCKED);
      x.loss = m_lost;
      x.err  = 8'(m_err);
      x.lcnt = 8'(m_lcnt);
      q.push_back(x);
   endfunction

   task automatic pair(input bit v, input bit k, input bit [1:0] e, input bit c);
      valid_i = v; komma_i = k; codeErr_i = e; clrCount_i = c;
      @(posedge clk_i);
      model_step(v, k, e, c);
      #1;
   endtask

   task automatic sync_up();
      for (int i = 0; i < P_COMMAS; i++) pair(1, 1, 2'b00, 0);
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) pair(0, i[0], 2'(i), 0);
   endtask

   task automatic do_reset(input bit check_async);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      if (check_async) begin
         chk("async_rst_synced", synced_o, 0);
         chk("async_rst_enrealign", enReAlign_o, 1);
         chk("async_rst_errcount", errCount_o, 0);
      end
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      model_reset();
   endtask

   // monitor: one popped expectation per clock, one line per transaction
   always @(negedge clk_i) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         n_txn++;
         chk("enReAlign", enReAlign_o, x.en);
         chk("synced", synced_o, x.syn);
         chk("syncLoss", syncLoss_o, x.loss);
         chk("errCount", errCount_o, x.err);
         chk("lossCount", lossCount_o, x.lcnt);
         $display("txn %0d: en=%0b sync=%0b loss=%0b err=%0d lcnt=%0d",
                  n_txn, enReAlign_o, synced_o, syncLoss_o, errCount_o, lossCount_o);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int err_pct;
      int r;
      bit [1:0] e;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_enrealign", enReAlign_o, 1);
      chk("reset_synced", synced_o, 0);
      chk("reset_syncloss", syncLoss_o, 0);
      chk("reset_errcount", errCount_o, 0);
      chk("reset_losscount", lossCount_o, 0);
      #1 rst_i = 1'b0;

      // acquisition with three commas
      pair(1, 1, 2'b00, 0);
      chk("acq_en_fall", enReAlign_o, 0);
      pair(1, 1, 2'b00, 0);
      chk("acq_not_yet_synced", synced_o, 0);
      pair(1, 1, 2'b00, 0);
      chk("acq_synced", synced_o, 1);
      chk("acq_errcount", errCount_o, 0);

      // sync loss: four single-symbol errors spaced by two good pairs
      pair(1, 0, 2'b00, 1);
      for (int i = 0; i < 4; i++) begin
         pair(1, 0, 2'b01, 0);
         if (i < 3) begin
            chk("loss_held", synced_o, 1);
            pair(1, 0, 2'b00, 0);
            pair(1, 0, 2'b00, 0);
         end
      end
      chk("loss_pulse", syncLoss_o, 1);
      chk("loss_errcount", errCount_o, 4);
      chk("loss_losscount", lossCount_o, LOSS_EN ? 1 : 0);
      pair(0, 0, 2'b00, 0);
      chk("loss_pulse_end", syncLoss_o, 0);

      // ACQ timeout
      pair(1, 1, 2'b00, 0);
      for (int i = 0; i < P_TMO - 1; i++) pair(1, 0, 2'b00, 0);
      chk("tmo_before", enReAlign_o, 0);
      pair(1, 0, 2'b00, 0);
      chk("tmo_enrealign", enReAlign_o, 1);
      chk("tmo_synced", synced_o, 0);

      // credit recovery
      sync_up();
      for (int i = 0; i < 3; i++) pair(1, 0, 2'b01, 0);
      for (int i = 0; i < 8; i++) pair(1, 0, 2'b00, 0);
      pair(1, 0, 2'b01, 0);
      pair(1, 0, 2'b01, 0);
      chk("credit_5th_bad_held", synced_o, 1);
      pair(1, 0, 2'b01, 0);
      chk("credit_6th_bad_lost", synced_o, 0);
      chk("credit_6th_pulse", syncLoss_o, 1);

      // error counter saturation and clear-with-increment
      sync_up();
      pair(1, 0, 2'b00, 1);
      while (m_err + 6 <= MAXV - 1) begin
         for (int i = 0; i < 3; i++) pair(1, 0, 2'b11, 0);
         for (int i = 0; i < 12; i++) pair(1, 0, 2'b00, 0);
      end
      while (m_err < MAXV - 1) begin
         pair(1, 0, 2'b01, 0);
         for (int i = 0; i < 4; i++) pair(1, 0, 2'b00, 0);
      end
      chk("sat_preload", errCount_o, MAXV - 1);
      pair(1, 0, 2'b11, 0);
      chk("sat_max", errCount_o, MAXV);
      pair(1, 0, 2'b10, 1);
      chk("clr_with_inc", errCount_o, 1);

      // idle in SYNC, LOS, ACQ
      idle_run(50);
      chk("idle_sync", synced_o, 1);
      do_reset(0);
      idle_run(50);
      chk("idle_los", enReAlign_o, 1);
      pair(1, 1, 2'b00, 0);
      idle_run(50);
      chk("idle_acq_en", enReAlign_o, 0);
      chk("idle_acq_sync", synced_o, 0);

      // async reset while synced with a non-zero count
      pair(1, 1, 2'b00, 0);
      pair(1, 1, 2'b00, 0);
      pair(1, 0, 2'b10, 0);
      do_reset(1);

      // randomized traffic
      for (int seg = 0; seg < 6; seg++) begin
         err_pct = (seg % 3) * 5 + 2;
         for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            e = (r < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
            pair($urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, e,
                 $urandom_range(0, 63) == 0);
         end
         if (seg == 2) do_reset(1);
      end

      valid_i = 1'b0; clrCount_i = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
      chk("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
